data_bus_decoder: RTL and testbench
===================================

DATA_BUS_DECODER -- requirements
Module: data_bus_decoder

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of downstream slave ports (1..8).
REQ-002 Parameter SLAVE_BASE, default {32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000}, base address per slave.
REQ-003 Parameter SLAVE_MASK, default 32'hFFFF_0000 for every slave, per-slave address compare mask.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, maximum wait cycles for a slave response (2..255).
REQ-005 Parameter ERR_RDATA_INTG, default 7'h00, rdata_intg value driven with decoder-generated error responses.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 m  ibex_data_bus.slave  -  upstream port from the Ibex data master.
REQ-009 s[NUM_SLAVES]  ibex_data_bus.master  -  downstream slave ports, index i decodes SLAVE_BASE[i].

Function
REQ-010 Decode: hit[i] = ((m.addr & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i])); the lowest hitting index wins; no hit means unmapped.
REQ-011 States: IDLE, WAIT_RESP, ERR_RESP.
REQ-012 IDLE, mapped request: s[sel].req = m.req; we, be, addr, wdata and wdata_intg go to all slaves; m.gnt = s[sel].gnt, combinational, zero added latency.
REQ-013 IDLE, mapped request, m.req && s[sel].gnt: latch sel into the pending index, clear the timeout counter, go to WAIT_RESP.
REQ-014 IDLE, unmapped request: m.gnt = 1 in the same cycle, no slave req asserted, go to ERR_RESP.
REQ-015 ERR_RESP: for exactly one cycle drive m.rvalid = 1, m.err = 1, m.rdata = 0 and m.rdata_intg = ERR_RDATA_INTG, then return to IDLE.
REQ-016 WAIT_RESP: m.rvalid, m.rdata, m.rdata_intg and m.err are taken combinationally from s[pending]; on s[pending].rvalid, return to IDLE.
REQ-017 WAIT_RESP: m.gnt = 0 and every s[i].req = 0, so at most one transaction is outstanding.
REQ-018 WAIT_RESP: the timeout counter increments each cycle without rvalid; when it reaches TIMEOUT_CYCLES, go to ERR_RESP.
REQ-019 rvalid from any slave is ignored outside WAIT_RESP, and from a non-pending slave inside WAIT_RESP; this covers late responses after a timeout.
REQ-020 Simultaneous rvalid and timeout expiry in one cycle: the slave response wins and the FSM returns to IDLE.
REQ-021 A new request is accepted in the cycle after m.rvalid (IDLE); there is no same-cycle response/grant overlap.
REQ-022 When no response is being driven: m.rvalid = 0, m.err = 0, m.rdata = 0, m.rdata_intg = 0.

Reset
REQ-023 While rst = 1: state = IDLE, pending index = 0, timeout counter = 0.
REQ-024 While rst = 1: m.gnt = 0, m.rvalid = 0, m.err = 0, and all s[i].req = 0.
REQ-025 Reset asserted mid-transaction discards the outstanding transaction; no response is produced for it after reset.

Structure
REQ-026 Package data_bus_pkg holds the FSM state enum and the MAX_SLAVES = 8 constant.
REQ-027 Address matching lives in a combinational sub-module data_bus_addr_match, which outputs sel and a hit flag.
REQ-028 Only the FSM, pending index and timeout counter are registered; all data paths are combinational muxes.

Verification
REQ-029 Read at 32'h0002_0004; slave 1 grants the same cycle and returns rvalid 2 cycles later with rdata 32'hCAFE_0001 -> m.gnt in the request cycle, m.rdata = 32'hCAFE_0001, m.err = 0, no other slave sees req.
REQ-030 Write to 32'h0009_0000 (unmapped) -> m.gnt in the same cycle, m.rvalid with m.err = 1 and m.rdata = 0 exactly one cycle later, all s[i].req = 0.
REQ-031 Slave 2 grants and never responds, TIMEOUT_CYCLES = 16 -> m.rvalid with m.err = 1 after 17 cycles; a later slave 2 rvalid is not forwarded.
REQ-032 Back-to-back requests to slave 0 then slave 3 -> the second m.gnt is withheld until the cycle after the first m.rvalid, and the responses route to the correct slaves.
REQ-033 rst pulsed while in WAIT_RESP -> outputs at reset values immediately, and no m.rvalid after reset even if the slave responds.
REQ-034 Slave rvalid in the same cycle the counter reaches TIMEOUT_CYCLES -> slave data forwarded with m.err = 0 and a single m.rvalid.

Source files
------------

// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_pkg
//  Brief    : Shared types and constants for the Ibex data-bus decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package data_bus_pkg;

   // Upper bound on downstream slave ports; internal arrays are sized to it
   localparam int MAX_SLAVES = 8;
   localparam int SEL_W      = $clog2(MAX_SLAVES);
   // Timeout counter width, enough for TIMEOUT_CYCLES up to 255
   localparam int CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RESP = 2'd1,
      ST_ERR_RESP  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/ibex_data_bus.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_data_bus
//  Brief    : Ibex-style data bus bundle (request/grant, response/valid).
//  Revision : 1.0 - initial release
// ============================================================================
interface ibex_data_bus;
   logic        req;
   logic        gnt;
   logic        rvalid;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [6:0]  wdata_intg;
   logic [31:0] rdata;
   logic [6:0]  rdata_intg;
   logic        err;

   // Side that issues requests
   modport master (
      output req, we, be, addr, wdata, wdata_intg,
      input  gnt, rvalid, rdata, rdata_intg, err
   );

   // Side that serves requests
   modport slave (
      input  req, we, be, addr, wdata, wdata_intg,
      output gnt, rvalid, rdata, rdata_intg, err
   );
endinterface
`default_nettype wire

// File: rtl/data_bus_addr_match.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_addr_match
//  Brief    : Combinational address decode; lowest matching slave index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module data_bus_addr_match
   import data_bus_pkg::*;
#(
   parameter int                          NUM_SLAVES = 4,
   // Index 0 is the rightmost element of the packed concatenation
   parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = {32'h0004_0000, 32'h0003_0000,
                                                         32'h0002_0000, 32'h0001_0000},
   parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_0000}}
) (
   input  logic [31:0]      addr,
   output logic [SEL_W-1:0] sel,
   output logic             hit
);

   // Scan from the top down so the lowest hitting index is the last written
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((addr & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i])) begin
            hit = 1'b1;
            sel = i[SEL_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_decoder
//  Brief    : 1-to-N Ibex data-bus decoder with one outstanding transaction,
//             decoder-generated error for unmapped addresses and a response
//             timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module data_bus_decoder #(
   parameter int                          NUM_SLAVES     = 4,
   // Index 0 is the rightmost element of the packed concatenation
   parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE     = {32'h0004_0000, 32'h0003_0000,
                                                             32'h0002_0000, 32'h0001_0000},
   parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_0000}},
   parameter int                          TIMEOUT_CYCLES = 16,
   parameter logic [6:0]                  ERR_RDATA_INTG = 7'h00
) (
   input  logic          clk,
   input  logic          rst,
   ibex_data_bus.slave   m,
   ibex_data_bus.master  s [NUM_SLAVES]
);

   import data_bus_pkg::*;

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   state_e           state;
   logic [SEL_W-1:0] pending;
   logic [CNT_W-1:0] tcnt;

   logic [SEL_W-1:0] sel;
   logic             hit;
   logic             req_en;

   logic             gnt_mux;
   logic             rvalid_mux;
   logic             err_mux;
   logic [31:0]      rdata_mux;
   logic [6:0]       rdata_intg_mux;

   // Slave-side inputs flattened into plain arrays so they can be indexed at
   // run time; lanes beyond NUM_SLAVES read as idle
   logic [MAX_SLAVES-1:0] slv_gnt;
   logic [MAX_SLAVES-1:0] slv_rvalid;
   logic [MAX_SLAVES-1:0] slv_err;
   logic [31:0]           slv_rdata      [MAX_SLAVES];
   logic [6:0]            slv_rdata_intg [MAX_SLAVES];

   logic [CNT_W-1:0] tcnt_inc;
   assign tcnt_inc = tcnt + 1'b1;

   data_bus_addr_match #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_addr_match (
      .addr (m.addr),
      .sel  (sel),
      .hit  (hit)
   );

   for (genvar i = 0; i < MAX_SLAVES; i++) begin : g_slave
      if (i < NUM_SLAVES) begin : g_used
         localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
         // Request fans out to every slave; only the selected one sees req
         assign s[i].req        = req_en && (sel == IDX);
         assign s[i].we         = m.we;
         assign s[i].be         = m.be;
         assign s[i].addr       = m.addr;
         assign s[i].wdata      = m.wdata;
         assign s[i].wdata_intg = m.wdata_intg;
         assign slv_gnt[i]        = s[i].gnt;
         assign slv_rvalid[i]     = s[i].rvalid;
         assign slv_err[i]        = s[i].err;
         assign slv_rdata[i]      = s[i].rdata;
         assign slv_rdata_intg[i] = s[i].rdata_intg;
      end else begin : g_unused
         assign slv_gnt[i]        = 1'b0;
         assign slv_rvalid[i]     = 1'b0;
         assign slv_err[i]        = 1'b0;
         assign slv_rdata[i]      = '0;
         assign slv_rdata_intg[i] = '0;
      end
   end

   // Sequencing of one outstanding transaction: grant, wait/timeout, respond
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pending <= '0;
         tcnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m.req) begin
                  if (!hit) begin
                     state <= ST_ERR_RESP;
                  end else if (slv_gnt[sel]) begin
                     pending <= sel;
                     tcnt    <= '0;
                     state   <= ST_WAIT_RESP;
                  end
               end
            end
            ST_WAIT_RESP: begin
               // A response arriving on the expiry cycle takes priority
               if (slv_rvalid[pending]) begin
                  state <= ST_IDLE;
               end else if (tcnt_inc == TIMEOUT_VAL) begin
                  state <= ST_ERR_RESP;
               end else begin
                  tcnt <= tcnt_inc;
               end
            end
            ST_ERR_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Upstream grant and response muxing; everything idles while rst is high
   always_comb begin
      req_en         = 1'b0;
      gnt_mux        = 1'b0;
      rvalid_mux     = 1'b0;
      err_mux        = 1'b0;
      rdata_mux      = '0;
      rdata_intg_mux = '0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (m.req) begin
                  if (hit) begin
                     req_en  = 1'b1;
                     gnt_mux = slv_gnt[sel];
                  end else begin
                     gnt_mux = 1'b1;
                  end
               end
            end
            ST_WAIT_RESP: begin
               if (slv_rvalid[pending]) begin
                  rvalid_mux     = 1'b1;
                  err_mux        = slv_err[pending];
                  rdata_mux      = slv_rdata[pending];
                  rdata_intg_mux = slv_rdata_intg[pending];
               end
            end
            ST_ERR_RESP: begin
               rvalid_mux     = 1'b1;
               err_mux        = 1'b1;
               rdata_intg_mux = ERR_RDATA_INTG;
            end
            default: begin
               rvalid_mux = 1'b0;
            end
         endcase
      end
   end

   assign m.gnt        = gnt_mux;
   assign m.rvalid     = rvalid_mux;
   assign m.err        = err_mux;
   assign m.rdata      = rdata_mux;
   assign m.rdata_intg = rdata_intg_mux;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_bus_decoder
//  Brief    : Directed self-checking bench for data_bus_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_decoder;

   localparam int NS = 4;

   logic clk;
   logic rst;

   ibex_data_bus m_bus ();
   ibex_data_bus s_bus [NS] ();

   logic        slv_gnt        [NS];
   logic        slv_rvalid     [NS];
   logic        slv_err        [NS];
   logic [31:0] slv_rdata      [NS];
   logic [6:0]  slv_rdata_intg [NS];
   logic [NS-1:0] slv_req;

   int checks;
   int errors;

   // Slave 2 uses a wider mask so it overlaps slave 1; lowest index must win
   data_bus_decoder #(
      .NUM_SLAVES     (NS),
      .SLAVE_BASE     ({32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}),
      .SLAVE_MASK     ({32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
      .TIMEOUT_CYCLES (16),
      .ERR_RDATA_INTG (7'h5A)
   ) dut (
      .clk (clk),
      .rst (rst),
      .m   (m_bus),
      .s   (s_bus)
   );

   for (genvar i = 0; i < NS; i++) begin : g_slv
      assign s_bus[i].gnt        = slv_gnt[i];
      assign s_bus[i].rvalid     = slv_rvalid[i];
      assign s_bus[i].err        = slv_err[i];
      assign s_bus[i].rdata      = slv_rdata[i];
      assign s_bus[i].rdata_intg = slv_rdata_intg[i];
      assign slv_req[i]          = s_bus[i].req;
   end

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_slaves();
      for (int i = 0; i < NS; i++) begin
         slv_gnt[i]        = 1'b0;
         slv_rvalid[i]     = 1'b0;
         slv_err[i]        = 1'b0;
         slv_rdata[i]      = 32'h0;
         slv_rdata_intg[i] = 7'h0;
      end
   endtask

   task automatic drive_req(input logic [31:0] a, input logic w);
      m_bus.req        = 1'b1;
      m_bus.we         = w;
      m_bus.be         = 4'hF;
      m_bus.addr       = a;
      m_bus.wdata      = 32'h1234_5678;
      m_bus.wdata_intg = 7'h11;
   endtask

   task automatic drop_req();
      m_bus.req = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      m_bus.req = 1'b0; m_bus.we = 1'b0; m_bus.be = 4'h0;
      m_bus.addr = 32'h0; m_bus.wdata = 32'h0; m_bus.wdata_intg = 7'h0;
      clear_slaves();

      // Reset: outputs forced idle even with a live, granted request present
      #2;
      drive_req(32'h0002_0004, 1'b0);
      slv_gnt[1] = 1'b1;
      settle();
      check("rst_gnt",    32'(m_bus.gnt),    32'd0);
      check("rst_rvalid", 32'(m_bus.rvalid), 32'd0);
      check("rst_err",    32'(m_bus.err),    32'd0);
      check("rst_req",    32'(slv_req),      32'd0);
      tick();
      tick();
      drop_req();
      clear_slaves();
      rst = 1'b0;
      tick();

      // Mapped read to slave 1, response two cycles later
      drive_req(32'h0002_0004, 1'b0);
      slv_gnt[1] = 1'b1;
      settle();
      check("rd_gnt", 32'(m_bus.gnt), 32'd1);
      check("rd_req", 32'(slv_req),   32'h2);
      check("rd_fanout_addr", s_bus[3].addr, 32'h0002_0004);
      tick();
      drop_req();
      slv_gnt[1] = 1'b0;
      settle();
      check("rd_wait_rvalid", 32'(m_bus.rvalid), 32'd0);
      tick();
      slv_rvalid[1] = 1'b1;
      slv_rdata[1]  = 32'hCAFE_0001;
      settle();
      check("rd_rvalid", 32'(m_bus.rvalid), 32'd1);
      check("rd_rdata",  m_bus.rdata,       32'hCAFE_0001);
      check("rd_err",    32'(m_bus.err),    32'd0);
      tick();
      clear_slaves();
      settle();
      check("rd_idle_rvalid", 32'(m_bus.rvalid), 32'd0);
      check("rd_idle_rdata",  m_bus.rdata,       32'd0);

      // Unmapped write: immediate grant, error response one cycle later
      drive_req(32'h0009_0000, 1'b1);
      settle();
      check("um_gnt", 32'(m_bus.gnt), 32'd1);
      check("um_req", 32'(slv_req),   32'd0);
      tick();
      drop_req();
      settle();
      check("um_rvalid", 32'(m_bus.rvalid),     32'd1);
      check("um_err",    32'(m_bus.err),        32'd1);
      check("um_rdata",  m_bus.rdata,           32'd0);
      check("um_intg",   32'(m_bus.rdata_intg), 32'h5A);
      check("um_req2",   32'(slv_req),          32'd0);
      tick();
      settle();
      check("um_once", 32'(m_bus.rvalid), 32'd0);

      // Slave 2 grants and never answers: timeout error in cycle 17
      drive_req(32'h0003_0010, 1'b0);
      slv_gnt[2] = 1'b1;
      settle();
      check("to_gnt", 32'(m_bus.gnt), 32'd1);
      check("to_req", 32'(slv_req),   32'h4);
      for (int k = 1; k <= 16; k++) begin
         tick();
         drop_req();
         slv_gnt[2] = 1'b0;
         // A non-pending slave's rvalid must not leak through
         slv_rvalid[0] = (k == 8);
         slv_rdata[0]  = 32'hBAD0_BAD0;
         settle();
         check("to_wait_rvalid", 32'(m_bus.rvalid), 32'd0);
      end
      tick();
      slv_rvalid[0] = 1'b0;
      settle();
      check("to_rvalid", 32'(m_bus.rvalid), 32'd1);
      check("to_err",    32'(m_bus.err),    32'd1);
      check("to_rdata",  m_bus.rdata,       32'd0);
      tick();
      slv_rvalid[2] = 1'b1;
      slv_rdata[2]  = 32'hDEAD_BEEF;
      settle();
      check("to_late_rvalid", 32'(m_bus.rvalid), 32'd0);
      tick();
      clear_slaves();

      // Back-to-back: slave 0 then slave 3, second grant held off
      drive_req(32'h0001_0000, 1'b0);
      slv_gnt[0] = 1'b1;
      settle();
      check("bb_gnt0", 32'(m_bus.gnt), 32'd1);
      check("bb_req0", 32'(slv_req),   32'h1);
      tick();
      drive_req(32'h0004_0000, 1'b1);
      slv_gnt[0] = 1'b0;
      slv_gnt[3] = 1'b1;
      settle();
      check("bb_hold_gnt", 32'(m_bus.gnt), 32'd0);
      check("bb_hold_req", 32'(slv_req),   32'd0);
      tick();
      slv_rvalid[0] = 1'b1;
      slv_rdata[0]  = 32'h1111_0000;
      slv_rdata[3]  = 32'hFFFF_FFFF;
      settle();
      check("bb_rsp0_gnt",   32'(m_bus.gnt),    32'd0);
      check("bb_rsp0_valid", 32'(m_bus.rvalid), 32'd1);
      check("bb_rsp0_rdata", m_bus.rdata,       32'h1111_0000);
      tick();
      slv_rvalid[0] = 1'b0;
      settle();
      check("bb_gnt3", 32'(m_bus.gnt), 32'd1);
      check("bb_req3", 32'(slv_req),   32'h8);
      tick();
      drop_req();
      slv_gnt[3]        = 1'b0;
      slv_rvalid[3]     = 1'b1;
      slv_err[3]        = 1'b1;
      slv_rdata[3]      = 32'h3333_0000;
      slv_rdata_intg[3] = 7'h2B;
      slv_rvalid[0]     = 1'b1;
      slv_rdata[0]      = 32'h0BAD_0000;
      settle();
      check("bb_rsp3_rdata", m_bus.rdata,           32'h3333_0000);
      check("bb_rsp3_err",   32'(m_bus.err),        32'd1);
      check("bb_rsp3_intg",  32'(m_bus.rdata_intg), 32'h2B);
      tick();
      clear_slaves();

      // Reset pulsed during WAIT_RESP discards the transaction
      drive_req(32'h0002_0008, 1'b0);
      slv_gnt[1] = 1'b1;
      settle();
      check("mr_gnt", 32'(m_bus.gnt), 32'd1);
      tick();
      rst = 1'b1;
      slv_rvalid[1] = 1'b1;
      slv_rdata[1]  = 32'h5555_AAAA;
      settle();
      check("mr_rvalid", 32'(m_bus.rvalid), 32'd0);
      check("mr_gnt_rst", 32'(m_bus.gnt),   32'd0);
      check("mr_req",    32'(slv_req),      32'd0);
      tick();
      rst = 1'b0;
      drop_req();
      slv_gnt[1] = 1'b0;
      settle();
      check("mr_post_rvalid", 32'(m_bus.rvalid), 32'd0);
      tick();
      check("mr_post_rvalid2", 32'(m_bus.rvalid), 32'd0);
      clear_slaves();
      tick();

      // Response coincides with the expiry cycle: slave data wins
      drive_req(32'h0004_0020, 1'b0);
      slv_gnt[3] = 1'b1;
      settle();
      check("tc_gnt", 32'(m_bus.gnt), 32'd1);
      for (int k = 1; k <= 15; k++) begin
         tick();
         drop_req();
         slv_gnt[3] = 1'b0;
      end
      tick();
      slv_rvalid[3] = 1'b1;
      slv_rdata[3]  = 32'h3434_3434;
      settle();
      check("tc_rvalid", 32'(m_bus.rvalid), 32'd1);
      check("tc_err",    32'(m_bus.err),    32'd0);
      check("tc_rdata",  m_bus.rdata,       32'h3434_3434);
      tick();
      slv_rvalid[3] = 1'b0;
      settle();
      check("tc_single", 32'(m_bus.rvalid), 32'd0);
      tick();
      settle();
      check("tc_single2", 32'(m_bus.rvalid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
